// File: rtl/rr_stream_mux.sv
// rr_stream_mux: CHANNELS-way stream multiplexer into a single registered
// output slot. Arbitration is either a fixed channel select or round-robin
// starting after the most recently granted channel. The output slot can
// drain and refill in the same cycle, so throughput is one word per cycle.
module rr_stream_mux #(
  parameter int N        = 32,
  parameter int CHANNELS = 8,
  parameter int S        = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*N-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready,
  input  logic                  mode,
  input  logic [S-1:0]          sel,
  output logic [N-1:0]          out_data,
  output logic [S-1:0]          out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // Registered state
  logic [N-1:0] out_data_q,   out_data_d;
  logic [S-1:0] out_chan_q,   out_chan_d;
  logic         out_valid_q,  out_valid_d;
  logic [S-1:0] last_grant_q, last_grant_d;

  // Arbitration intermediates
  logic         rr_found;
  logic [S-1:0] rr_idx;
  logic         fixed_hit;
  logic         grant_found;
  logic [S-1:0] grant_idx;
  logic         accept;
  logic         transfer;
  logic [N-1:0] grant_data;

  // Round-robin search: first requester above last_grant, else wrap to the lowest.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rr_found && in_valid[i] && (i > int'(last_grant_q))) begin
        rr_found = 1'b1;
        rr_idx   = S'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!rr_found && in_valid[i] && (i <= int'(last_grant_q))) begin
        rr_found = 1'b1;
        rr_idx   = S'(i);
      end
    end
  end

  // Fixed select: an out-of-range sel matches no channel and so never grants.
  always_comb begin
    fixed_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(sel) == i) fixed_hit = in_valid[i];
    end
  end

  // Grant resolution and handshake; in_data never feeds in_ready.
  always_comb begin
    grant_found = mode ? rr_found : fixed_hit;
    grant_idx   = mode ? rr_idx : sel;
    accept      = !out_valid_q || out_ready;
    transfer    = !rst && accept && grant_found;
    in_ready    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = transfer && (grant_idx == S'(i));
    end
  end

  // Data path: select the granted channel's word.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == S'(i)) grant_data = in_data[i*N +: N];
    end
  end

  // Next-state: load on transfer, empty when drained with nothing to refill.
  always_comb begin
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (transfer) begin
      out_data_d   = grant_data;
      out_chan_d   = grant_idx;
      out_valid_d  = 1'b1;
      last_grant_d = grant_idx;
    end else if (accept) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers with synchronous reset; reset wins over any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= S'(CHANNELS - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule
